// File: rtl/mux_rr_arbiter_if.sv
// Requester/downstream bundle for the round-robin pixel arbiter.
// master: arbiter side; slave: producer/consumer side.
interface mux_rr_arbiter_if;
    localparam int unsigned LANES = 8;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned IDX_W = 3;

    logic [LANES-1:0]       req_i;
    logic [LANES*PIX_W-1:0] pix_i;
    logic [LANES-1:0]       gnt_o;
    logic [IDX_W-1:0]       sel_o;
    logic [PIX_W-1:0]       o_data;
    logic                   o_valid;
    logic                   o_ready;
    logic                   busy_o;

    modport master (
        input  req_i, pix_i, o_ready,
        output gnt_o, sel_o, o_data, o_valid, busy_o
    );

    modport slave (
        output req_i, pix_i, o_ready,
        input  gnt_o, sel_o, o_data, o_valid, busy_o
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 8-lane pixel select path, with bounded
// burst ownership and a registered valid/ready output stage.
module mux_rr_arbiter #(
    parameter int unsigned BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    mux_rr_arbiter_if.master  bus
);
    localparam int unsigned LANES = 8;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 5;

    typedef enum logic {ST_IDLE, ST_BURST} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [PIX_W-1:0]   data_q, data_d;
    logic               valid_q, valid_d;

    logic               accept_c;
    logic               win_found_c;
    logic [IDX_W-1:0]   win_idx_c;
    logic               cap_c;
    logic [IDX_W-1:0]   cap_lane_c;
    logic [LANES-1:0]   gnt_c;

    assign accept_c = ~valid_q | bus.o_ready;

    // First requester at or after ptr; descending scan lets the nearest one win.
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        for (int k = int'(LANES) - 1; k >= 0; k--) begin
            if (bus.req_i[ptr_q + IDX_W'(k)]) begin
                win_found_c = 1'b1;
                win_idx_c   = ptr_q + IDX_W'(k);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        data_d     = data_q;
        valid_d    = valid_q;
        cap_c      = 1'b0;
        cap_lane_c = '0;

        if (accept_c) begin
            case (state_q)
                ST_IDLE: begin
                    if (win_found_c) begin
                        cap_c      = 1'b1;
                        cap_lane_c = win_idx_c;
                        cnt_d      = CNT_W'(1);
                        if (BURST == 1) begin
                            ptr_d = win_idx_c + IDX_W'(1);
                        end else begin
                            state_d = ST_BURST;
                        end
                    end else begin
                        valid_d = 1'b0;
                    end
                end
                ST_BURST: begin
                    if (bus.req_i[sel_q]) begin
                        cap_c      = 1'b1;
                        cap_lane_c = sel_q;
                        cnt_d      = cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) == CNT_W'(BURST)) begin
                            ptr_d   = sel_q + IDX_W'(1);
                            state_d = ST_IDLE;
                        end
                    end else begin
                        // Owner released early: drop the consumed beat, one bubble.
                        valid_d = 1'b0;
                        ptr_d   = sel_q + IDX_W'(1);
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (cap_c) begin
            sel_d   = cap_lane_c;
            data_d  = bus.pix_i[{cap_lane_c, 3'b000} +: PIX_W];
            valid_d = 1'b1;
        end
    end

    assign gnt_c = cap_c ? (LANES'(1) << cap_lane_c) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bus.gnt_o   = rst ? '0 : gnt_c;
    assign bus.sel_o   = sel_q;
    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;
    assign bus.busy_o  = (state_q == ST_BURST);
endmodule
